// File: rtl/aoc_pkg.sv
// Shared constants and types for the dial-solver feeders: ASCII codes, feeder states, count limits.
// Pure definitions; no logic, no latency.
package aoc_pkg;

  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIGITS = 2'd1,
    SKIP   = 2'd2,
    PEND   = 2'd3
  } feed_state_t;

  localparam int unsigned DEF_INPUT_WIDTH = 10;
  localparam int unsigned CNT_MAX = (32'd1 << DEF_INPUT_WIDTH) - 32'd1;

  function automatic int unsigned cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CH_0) && (b <= CH_9);
  endfunction

endpackage

// File: rtl/aoc_pacer.sv
// Command pacing counter: load arms count+GAP+1 cycles of quiet, idle once it has run down.
// free_next flags that a strobe registered on the coming edge lands exactly on the spacing limit.
module aoc_pacer #(
  parameter int INPUT_WIDTH = 10,
  parameter int GAP         = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [INPUT_WIDTH-1:0] count,
  output logic                   idle,
  output logic                   free_next
);

  localparam int PW = $clog2((1 << INPUT_WIDTH) + GAP + 1) + 1;

  logic [PW-1:0] pace;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pace <= '0;
    end else if (load) begin
      pace <= PW'(count) + PW'(GAP + 1);
    end else if (pace != '0) begin
      pace <= pace - PW'(1);
    end
  end

  assign idle = (pace == '0);
  // The strobe is registered, so a decision taken while pace==1 lands on the cycle pace hits 0.
  assign free_next = (pace <= PW'(1));

endmodule

// File: rtl/aoc_dial_feeder.sv
// Parses "L68\n"-style ASCII lines into paced {direction, count} strobes for the dial solver.
// Strobe two edges after the terminating byte when idle; in_ready drops while a command waits on the pacer.
module aoc_dial_feeder
  import aoc_pkg::*;
#(
  parameter int INPUT_WIDTH = 10,
  parameter int GAP         = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_data,
  input  logic                   in_last,
  output logic                   valid,
  output logic                   step_direction,
  output logic [INPUT_WIDTH-1:0] step_count,
  output logic                   err,
  output logic                   done
);

  localparam int AW = INPUT_WIDTH + 4;
  localparam logic [AW-1:0] MAX_W = AW'(cnt_max(INPUT_WIDTH));

  feed_state_t            state;
  logic [INPUT_WIDTH-1:0] acc;
  logic                   dir_q;
  logic                   have_dig;
  logic                   ovf;
  logic                   eof;

  logic                   take;
  logic                   byte_digit;
  logic [AW-1:0]          acc_mul;
  logic                   mul_ovf;
  logic                   pace_idle;
  logic                   pace_free;
  logic                   fire;

  assign take       = in_valid && in_ready;
  assign byte_digit = is_digit(in_data);
  // acc never exceeds CNT_MAX, so acc*10+9 always fits in four extra bits.
  assign acc_mul    = ({4'b0, acc} * AW'(10)) + {{INPUT_WIDTH{1'b0}}, in_data[3:0]};
  assign mul_ovf    = (acc_mul > MAX_W);
  assign fire       = (state == PEND) && pace_free;

  aoc_pacer #(
    .INPUT_WIDTH(INPUT_WIDTH),
    .GAP        (GAP)
  ) u_pacer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (fire),
    .count    (acc),
    .idle     (pace_idle),
    .free_next(pace_free)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      acc            <= '0;
      dir_q          <= 1'b0;
      have_dig       <= 1'b0;
      ovf            <= 1'b0;
      eof            <= 1'b0;
      in_ready       <= 1'b0;
      valid          <= 1'b0;
      step_direction <= 1'b0;
      step_count     <= '0;
      err            <= 1'b0;
      done           <= 1'b0;
    end else begin
      valid    <= 1'b0;
      // Branches that enter or stay in PEND override this with 0.
      in_ready <= !(eof || (take && in_last));
      if (take && in_last) begin
        eof <= 1'b1;
      end
      if (eof && (state != PEND) && pace_idle) begin
        done <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (take) begin
            if ((in_data == CH_L) || (in_data == CH_R)) begin
              dir_q    <= (in_data == CH_R);
              acc      <= '0;
              have_dig <= 1'b0;
              ovf      <= 1'b0;
              state    <= DIGITS;
            end else if ((in_data != CH_LF) && (in_data != CH_CR)) begin
              err   <= 1'b1;
              state <= SKIP;
            end
          end
        end

        DIGITS: begin
          if (take) begin
            if (byte_digit) begin
              have_dig <= 1'b1;
              if (mul_ovf) begin
                ovf <= 1'b1;
              end else begin
                acc <= acc_mul[INPUT_WIDTH-1:0];
              end
              // A final digit closes the line even without a newline.
              if (in_last) begin
                if (mul_ovf || ovf) begin
                  err   <= 1'b1;
                  state <= IDLE;
                end else begin
                  state    <= PEND;
                  in_ready <= 1'b0;
                end
              end
            end else if ((in_data == CH_LF) || ((in_data == CH_CR) && in_last)) begin
              if (have_dig && !ovf) begin
                state    <= PEND;
                in_ready <= 1'b0;
              end else begin
                err   <= 1'b1;
                state <= IDLE;
              end
            end else if (in_data != CH_CR) begin
              err   <= 1'b1;
              state <= SKIP;
            end
          end
        end

        SKIP: begin
          if (take && (in_data == CH_LF)) begin
            state <= IDLE;
          end
        end

        PEND: begin
          if (pace_free) begin
            valid          <= 1'b1;
            step_count     <= acc;
            step_direction <= dir_q;
            state          <= IDLE;
          end else begin
            in_ready <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aoc_dial_feeder.sv
// Directed bench for aoc_dial_feeder: table of ASCII inputs with expected commands, plus reset sequences.
module tb_aoc_dial_feeder;

  localparam int W = 10;
  localparam int G = 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_ready;
  logic         valid;
  logic         step_direction;
  logic [W-1:0] step_count;
  logic         err;
  logic         done;

  aoc_dial_feeder #(.INPUT_WIDTH(W), .GAP(G)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_last       (in_last),
    .valid         (valid),
    .step_direction(step_direction),
    .step_count    (step_count),
    .err           (err),
    .done          (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [10:0] got_cmd[$];
  int          got_cyc[$];
  int          done_cyc = -1;
  logic        done_d = 1'b0;
  int          stall = 0;

  always @(negedge clk) begin
    if (valid) begin
      got_cmd.push_back({step_direction, step_count});
      got_cyc.push_back(cyc);
    end
    if (done && !done_d) done_cyc = cyc;
    done_d = done;
    if (in_valid && !in_ready) stall++;
  end

  typedef struct {
    logic [127:0] txt;
    int           len;
    int           n;
    logic [10:0]  c0;
    logic [10:0]  c1;
    logic [10:0]  c2;
    logic         e;
    logic         exact;
  } vec_t;

  vec_t tbl[10];
  int checks = 0;
  int failures = 0;

  function automatic vec_t mk(input logic [127:0] t, input int l, input int n,
                              input logic [10:0] a, input logic [10:0] b, input logic [10:0] c,
                              input logic e, input logic x);
    vec_t v;
    v.txt = t; v.len = l; v.n = n; v.c0 = a; v.c1 = b; v.c2 = c; v.e = e; v.exact = x;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected in [%0d,%0d]", name, act, lo, hi);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send(input logic [127:0] t, input int len, input logic mark_last, output int acc_cyc);
    int budget;
    for (int i = 0; i < len; i++) begin
      in_valid = 1'b1;
      in_data  = t[8*(len-1-i) +: 8];
      in_last  = mark_last && (i == len - 1);
      budget = 0;
      while (!in_ready && budget < 500) begin
        @(negedge clk);
        budget++;
      end
      if (!in_ready) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: byte %0d not accepted within %0d cycles", i, budget);
      end
      @(negedge clk);
    end
    acc_cyc  = cyc;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int budget;
    budget = 0;
    while (!done && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    chk(name, {31'd0, done}, 32'd1);
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int base, st0, acc_cyc, n_got, d, c, tl;
    logic [10:0] ex[3];
    ex[0] = v.c0; ex[1] = v.c1; ex[2] = v.c2;
    do_reset();
    base = got_cmd.size();
    st0  = stall;
    send(v.txt, v.len, 1'b1, acc_cyc);
    wait_done($sformatf("v%0d_done", id));
    n_got = got_cmd.size() - base;
    chk($sformatf("v%0d_ncmd", id), n_got, v.n);
    chk($sformatf("v%0d_err", id), {31'd0, err}, {31'd0, v.e});
    for (int i = 0; i < v.n && i < n_got; i++) begin
      chk($sformatf("v%0d_cmd%0d", id, i), {21'd0, got_cmd[base+i]}, {21'd0, ex[i]});
      if (i > 0) begin
        d = got_cyc[base+i] - got_cyc[base+i-1];
        c = int'(ex[i-1][9:0]);
        if (v.exact) chk($sformatf("v%0d_gap%0d", id, i), d, c + 1 + G);
        else chk_range($sformatf("v%0d_gap%0d", id, i), d, c + 1 + G, 100000);
      end
    end
    if (v.n == 0) begin
      chk($sformatf("v%0d_done_at", id), done_cyc, acc_cyc + 1);
    end else if (n_got == v.n) begin
      tl = got_cyc[base+n_got-1];
      c  = int'(ex[v.n-1][9:0]);
      chk_range($sformatf("v%0d_done_at", id), done_cyc, tl + c + 2 + G, tl + c + 3 + G);
    end
    if (v.exact) chk_range($sformatf("v%0d_stalled", id), stall - st0, 1, 100000);
  endtask

  initial begin
    int base, a;
    tbl[0] = mk("L68\nR48\n", 8, 2, {1'b0, 10'd68}, {1'b1, 10'd48}, 11'd0, 1'b0, 1'b1);
    tbl[1] = mk("R0\nL5", 5, 2, {1'b1, 10'd0}, {1'b0, 10'd5}, 11'd0, 1'b0, 1'b0);
    tbl[2] = mk("R1024\nL3\n", 9, 1, {1'b0, 10'd3}, 11'd0, 11'd0, 1'b1, 1'b0);
    tbl[3] = mk("X12\n\r\nR7\r\n", 10, 1, {1'b1, 10'd7}, 11'd0, 11'd0, 1'b1, 1'b0);
    tbl[4] = mk("R3\nL5\nR2\n", 9, 3, {1'b1, 10'd3}, {1'b0, 10'd5}, {1'b1, 10'd2}, 1'b0, 1'b1);
    tbl[5] = mk("R1023\n", 6, 1, {1'b1, 10'd1023}, 11'd0, 11'd0, 1'b0, 1'b0);
    tbl[6] = mk("L\n", 2, 0, 11'd0, 11'd0, 11'd0, 1'b1, 1'b0);
    tbl[7] = mk("\n", 1, 0, 11'd0, 11'd0, 11'd0, 1'b0, 1'b0);
    tbl[8] = mk("L9\r", 3, 1, {1'b0, 10'd9}, 11'd0, 11'd0, 1'b0, 1'b0);
    tbl[9] = mk("R5x\nL2\n", 7, 1, {1'b0, 10'd2}, 11'd0, 11'd0, 1'b1, 1'b0);

    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_dir", {31'd0, step_direction}, 32'd0);
    chk("rst_count", {22'd0, step_count}, 32'd0);

    for (int i = 0; i < 10; i++) run_vec(tbl[i], i);

    // Last vector leaves err and done set; an async reset must clear them at once.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_err", {31'd0, err}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_valid", {31'd0, valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    base = got_cmd.size();
    send("L4", 2, 1'b0, a);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send("R2\n", 3, 1'b1, a);
    wait_done("mid_done");
    chk("mid_ncmd", got_cmd.size() - base, 1);
    if (got_cmd.size() > base) chk("mid_cmd", {21'd0, got_cmd[base]}, {21'd0, 1'b1, 10'd2});
    chk("mid_err", {31'd0, err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
